hero_write_rx: RTL and testbench
================================

Name: hero_write_rx

Overview:
- Receive stage directly downstream of the hero write bus; consumes one `hero_write_t` beat per cycle.
- The bus has no backpressure.
- Frames transactions: zero or more VALID beats followed by one DONE beat.
- Buffers beats in a FIFO and presents them to the consumer on a valid/ready interface with last/err marking.
- Drops traffic cleanly on overflow or over-length transactions and counts the drops.

Parameters:
- DEPTH, 8, FIFO entries; legal range ≥2.
- MAX_BEATS, 16, maximum beats per transaction including DONE; legal range ≥2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high, one clock domain.
- in_hero  in  60  `hero_write_t` beat. Packing: [59:58] cycle_type (IDLE=0, VALID=1, DONE=2), [57:22] wdat, [21:1] another_type_reference (3 x `sub_def_t`), [0] clk_en.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_wdat  out  36  head wdat.
- out_sub  out  21  head another_type_reference.
- out_last  out  1  head ends a transaction.
- out_err  out  1  head is a truncated-transaction terminator.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- drop_cnt  out  CNT_W  dropped transactions, saturating.
- err_pulse  out  1  one-cycle pulse per truncation or drop event.
- busy  out  1  FSM not in IDLE_S.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE_S, beat_cnt 0.
- Reset mid-transaction: FIFO flushed and partial transaction discarded; it is not counted as a drop.

Beat qualification:
- A beat is live when clk_en=1 and cycle_type is VALID or DONE.
- clk_en=0 ignores the cycle regardless of cycle_type.
- cycle_type=3 is treated as IDLE.
- IDLE cycles inside a transaction are legal gaps.

Admission:
- Admission uses the registered occupancy C at cycle start; a same-cycle pop does not free space for admission.
- FIFO entry is {wdat, sub, last, err}.

FSM states: IDLE_S, XFER_S, DROP_S.
- IDLE_S + DONE:
  - C<DEPTH: push last=1, err=0; stay in IDLE_S.
  - C==DEPTH: drop the beat, drop_cnt+1, err_pulse.
- IDLE_S + VALID:
  - C<DEPTH-1: push last=0, beat_cnt=1, go XFER_S.
  - C==DEPTH-1: push last=1, err=1, err_pulse, go DROP_S.
  - C==DEPTH: push nothing, drop_cnt+1, err_pulse, go DROP_S.
- XFER_S + DONE: push last=1, err=0; beat_cnt=0; go IDLE_S. Always fits, because XFER_S guarantees C≤DEPTH-1.
- XFER_S + VALID:
  - If C==DEPTH-1 or beat_cnt==MAX_BEATS-1: push last=1, err=1, err_pulse, go DROP_S.
  - Otherwise: push last=0, beat_cnt+1.
- DROP_S:
  - Discards all live beats.
  - DONE returns to IDLE_S.
  - A VALID-started drop with C==DEPTH already incremented drop_cnt on entry; DROP_S adds nothing further.

Output side:
- FIFO is registered, not fall-through: a push at edge N shows out_valid at N+1 at the earliest.
- Pop when out_valid && out_ready.
- Head fields are stable while out_valid && !out_ready.
- Push and pop in the same cycle: occupancy unchanged.
- Pop when empty is impossible, because out_valid=0.

Counters and flags:
- drop_cnt saturates at 2^CNT_W-1.
- err_pulse is asserted the cycle after the triggering beat (registered) and lasts exactly one cycle per event.
- busy = state != IDLE_S, registered.

Test Plan:
1. Bench DEPTH=4, MAX_BEATS=4, out_ready=1. Input VALID(wdat=0x1), VALID(0x2), DONE(0x3) -> three outputs, wdat 1,2,3, out_last=0,0,1, out_err=0; first out_valid exactly 1 cycle after the first beat.
2. clk_en=0 with cycle_type=DONE, then IDLE gaps between VALID(0xA) and DONE(0xB) -> exactly two entries (A, last=0; B, last=1); fifo_count never exceeds 2.
3. out_ready=0, send a 3-beat transaction then a 2-beat transaction -> entries A0, A1, A2(last) then B0 as last=1,err=1 (C was 3=DEPTH-1); err_pulse once; B1 dropped; drop_cnt=0; fifo_count=4.
4. FIFO full (4 entries, out_ready=0), send DONE then VALID,VALID,DONE -> no pushes; drop_cnt=2; two err_pulses; busy high from the VALID until the cycle after its DONE.
5. Send 6 VALIDs then DONE with out_ready=1 -> beats 0-2 last=0, beat 3 last=1,err=1, beats 4-6 discarded; next transaction accepted normally.
6. Assert rst mid-transaction with 2 entries queued -> out_valid=0, fifo_count=0, busy=0 asynchronously; a fresh DONE after release yields a single last=1 entry.

Source files
------------

// File: rtl/hero_write_rx.sv
// hero_write_rx
//   Receive stage behind the hero write bus. It frames transactions, which are
//   zero or more VALID beats closed by one DONE beat. Admitted beats are
//   buffered in a registered FIFO and presented on a valid/ready interface.
//   Traffic that cannot be held is dropped. A transaction cut short by FIFO
//   space or by MAX_BEATS gets one terminator entry with last=1, err=1.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   in_hero      60-bit beat: [59:58] cycle_type, [57:22] wdat,
//                [21:1] sub (3 x sub_def_t), [0] clk_en
//   out_valid    FIFO head valid
//   out_ready    consumer accepts the head this cycle
//   out_wdat     head wdat
//   out_sub      head sub fields
//   out_last     head ends a transaction
//   out_err      head is a truncated-transaction terminator
//   fifo_count   FIFO occupancy
//   drop_cnt     dropped transactions (saturating)
//   err_pulse    one-cycle pulse per truncation/drop event
//   busy         framer is inside a transaction (XFER_S or DROP_S)
module hero_write_rx #(
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [59:0]                in_hero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [35:0]                out_wdat,
    output logic [20:0]                out_sub,
    output logic                       out_last,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       err_pulse,
    output logic                       busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(MAX_BEATS+1);
    localparam int EW = 36 + 21 + 2;

    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] C_ALMOST = CW'(DEPTH-1);
    localparam logic [BW-1:0] B_LIMIT  = BW'(MAX_BEATS-1);

    typedef enum logic [1:0] {IDLE_S, XFER_S, DROP_S} state_t;

    // Input decode. cycle_type 3 falls through as "not live".
    logic [1:0]  in_type;
    logic [35:0] in_wdat;
    logic [20:0] in_sub;
    logic        in_en;
    logic        is_valid, is_done;

    assign in_type  = in_hero[59:58];
    assign in_wdat  = in_hero[57:22];
    assign in_sub   = in_hero[21:1];
    assign in_en    = in_hero[0];
    assign is_valid = in_en && (in_type == 2'd1);
    assign is_done  = in_en && (in_type == 2'd2);

    // FIFO storage
    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [EW-1:0]  head;
    logic           pop;

    // Framer
    state_t         state, state_n;
    logic [BW-1:0]  beat_cnt, beat_cnt_n;
    logic           push, push_last, push_err;
    logic           err_set, drop_inc;

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        push       = 1'b0;
        push_last  = 1'b0;
        push_err   = 1'b0;
        err_set    = 1'b0;
        drop_inc   = 1'b0;
        // All admission decisions use the registered count; a pop in the
        // same cycle does not make room.
        unique case (state)
            IDLE_S: begin
                if (is_done) begin
                    if (count != C_FULL) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                        err_set  = 1'b1;
                    end
                end else if (is_valid) begin
                    if (count < C_ALMOST) begin
                        push       = 1'b1;
                        beat_cnt_n = BW'(1);
                        state_n    = XFER_S;
                    end else if (count == C_ALMOST) begin
                        // Only room for a terminator: the transaction is truncated.
                        push      = 1'b1;
                        push_last = 1'b1;
                        push_err  = 1'b1;
                        err_set   = 1'b1;
                        state_n   = DROP_S;
                    end else begin
                        drop_inc = 1'b1;
                        err_set  = 1'b1;
                        state_n  = DROP_S;
                    end
                end
            end
            XFER_S: begin
                // A slot is always reserved for the closing entry, so DONE fits.
                if (is_done) begin
                    push       = 1'b1;
                    push_last  = 1'b1;
                    beat_cnt_n = '0;
                    state_n    = IDLE_S;
                end else if (is_valid) begin
                    push = 1'b1;
                    if (count == C_ALMOST || beat_cnt == B_LIMIT) begin
                        push_last  = 1'b1;
                        push_err   = 1'b1;
                        err_set    = 1'b1;
                        beat_cnt_n = '0;
                        state_n    = DROP_S;
                    end else begin
                        beat_cnt_n = beat_cnt + BW'(1);
                    end
                end
            end
            DROP_S: begin
                if (is_done) state_n = IDLE_S;
            end
            default: state_n = IDLE_S;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE_S;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            beat_cnt  <= beat_cnt_n;
            busy      <= (state_n != IDLE_S);
            err_pulse <= err_set;
            if (drop_inc && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: head fields are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_wdat, in_sub, push_last, push_err};
    end

    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign fifo_count = count;
    assign out_wdat   = out_valid ? head[EW-1 -: 36] : '0;
    assign out_sub    = out_valid ? head[22:2]       : '0;
    assign out_last   = out_valid && head[1];
    assign out_err    = out_valid && head[0];

endmodule

// File: tb/tb_hero_write_rx.sv
module tb_hero_write_rx;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [59:0] in_hero;
    logic        out_valid, out_ready;
    logic [35:0] out_wdat;
    logic [20:0] out_sub;
    logic        out_last, out_err;
    logic [2:0]  fifo_count;
    logic [CNT_W-1:0] drop_cnt;
    logic        err_pulse, busy;

    hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAXB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_hero(in_hero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wdat(out_wdat), .out_sub(out_sub),
        .out_last(out_last), .out_err(out_err),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt),
        .err_pulse(err_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    int ntot = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [20:0] sub_of(input logic [35:0] w);
        return w[20:0] ^ 21'h0a5a5;
    endfunction

    // ---------------- behavioural model ----------------
    // Transaction-level view: a queue of accepted entries, whether we are
    // inside a transaction / discarding one, and beats admitted so far.
    typedef struct packed {
        logic [35:0] w;
        logic [20:0] s;
        logic        l;
        logic        e;
    } ent_t;

    ent_t mq[$];
    int   m_mode = 0;   // 0 between transactions, 1 receiving, 2 discarding
    int   m_beats = 0;
    int   m_drop = 0;
    bit   m_err = 0;
    bit   m_busy = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete(); m_mode = 0; m_beats = 0; m_drop = 0; m_err = 0; m_busy = 0;
        end else begin
            int   room;
            bit   do_pop, do_push, live_v, live_d;
            ent_t e;
            room    = DEPTH - mq.size();
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = 0;
            live_v  = in_hero[0] && in_hero[59:58] == 2'd1;
            live_d  = in_hero[0] && in_hero[59:58] == 2'd2;
            e.w = in_hero[57:22]; e.s = in_hero[21:1]; e.l = 0; e.e = 0;
            m_err = 0;
            if (m_mode == 0) begin
                if (live_d) begin
                    if (room > 0) begin do_push = 1; e.l = 1; end
                    else begin m_drop++; m_err = 1; end
                end else if (live_v) begin
                    if (room >= 2) begin do_push = 1; m_beats = 1; m_mode = 1; end
                    else if (room == 1) begin do_push = 1; e.l = 1; e.e = 1; m_err = 1; m_mode = 2; end
                    else begin m_drop++; m_err = 1; m_mode = 2; end
                end
            end else if (m_mode == 1) begin
                if (live_d) begin do_push = 1; e.l = 1; m_mode = 0; end
                else if (live_v) begin
                    do_push = 1;
                    if (room == 1 || m_beats + 1 == MAXB) begin
                        e.l = 1; e.e = 1; m_err = 1; m_mode = 2;
                    end else m_beats++;
                end
            end else if (live_d) m_mode = 0;
            if (m_drop > (1 << CNT_W) - 1) m_drop = (1 << CNT_W) - 1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            m_busy = (m_mode != 0);
        end
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("fifo_count", fifo_count, mq.size());
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_pulse", err_pulse, m_err);
        chk("busy", busy, m_busy);
        if (mq.size() != 0) begin
            chk("head", {out_wdat, out_sub, out_last, out_err},
                {mq[0].w, mq[0].s, mq[0].l, mq[0].e});
        end
    end

    // Output log, error pulse count, peak occupancy
    logic [35:0] lw[$];
    bit          ll[$], le[$];
    logic [35:0] ew[$];
    bit          el[$], ee[$];
    int          pulses = 0;
    int          maxc = 0;

    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            lw.push_back(out_wdat); ll.push_back(out_last); le.push_back(out_err);
        end
        if (err_pulse) pulses++;
        if (fifo_count > maxc) maxc = fifo_count;
    end

    task automatic exp_add(input logic [35:0] w, input bit l, input bit e);
        ew.push_back(w); el.push_back(l); ee.push_back(e);
    endtask

    task automatic check_log(input string nm);
        chk({nm, " count"}, lw.size(), ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            if (i < lw.size())
                chk($sformatf("%s entry%0d", nm, i), {lw[i], ll[i], le[i]}, {ew[i], el[i], ee[i]});
        end
        lw.delete(); ll.delete(); le.delete();
        ew.delete(); el.delete(); ee.delete();
    endtask

    // Present a beat; returns 1 time unit after the edge that samples it.
    task automatic drive(input logic [1:0] ct, input logic [35:0] w, input logic en);
        in_hero = {ct, w, sub_of(w), en};
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'd0, 36'h0, 1'b1);
    endtask

    localparam logic [1:0] V = 2'd1, D = 2'd2, I = 2'd0;

    initial begin
        rst = 1'b1; in_hero = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset busy", busy, 0);
        chk("reset err_pulse", err_pulse, 0);
        rst = 1'b0;
        idle(2);

        // 1: simple 3-beat transaction
        chk("t1 pre out_valid", out_valid, 0);
        drive(V, 36'h1, 1);
        chk("t1 first latency", {out_valid, out_wdat}, {1'b1, 36'h1});
        drive(V, 36'h2, 1);
        drive(D, 36'h3, 1);
        idle(4);
        exp_add(36'h1, 0, 0); exp_add(36'h2, 0, 0); exp_add(36'h3, 1, 0);
        check_log("t1");

        // 2: clk_en=0 beat ignored, IDLE gaps inside a transaction
        maxc = 0;
        drive(D, 36'h55, 0);
        drive(V, 36'hA, 1);
        idle(2);
        drive(I, 36'h77, 1);
        drive(2'd3, 36'h66, 1);
        drive(D, 36'hB, 1);
        idle(4);
        exp_add(36'hA, 0, 0); exp_add(36'hB, 1, 0);
        check_log("t2");
        chk("t2 max occupancy<=2", maxc <= 2, 1);

        // 3: consumer stalled, second transaction truncated at DEPTH-1
        out_ready = 1'b0; pulses = 0;
        drive(V, 36'hA0, 1); drive(V, 36'hA1, 1); drive(D, 36'hA2, 1);
        drive(V, 36'hB0, 1); drive(V, 36'hB1, 1); drive(D, 36'hB2, 1);
        idle(2);
        chk("t3 fifo_count", fifo_count, 4);
        chk("t3 drop_cnt", drop_cnt, 0);
        chk("t3 pulses", pulses, 1);
        chk("t3 head", out_wdat, 36'hA0);

        // 4: full FIFO, everything dropped
        pulses = 0;
        drive(D, 36'hC0, 1);
        chk("t4 busy after DONE", busy, 0);
        drive(V, 36'hC1, 1);
        chk("t4 busy after VALID", busy, 1);
        drive(V, 36'hC2, 1);
        chk("t4 busy mid drop", busy, 1);
        drive(D, 36'hC3, 1);
        chk("t4 busy after DONE close", busy, 0);
        idle(2);
        chk("t4 drop_cnt", drop_cnt, 2);
        chk("t4 pulses", pulses, 2);
        chk("t4 fifo_count", fifo_count, 4);
        out_ready = 1'b1;
        idle(6);
        exp_add(36'hA0, 0, 0); exp_add(36'hA1, 0, 0); exp_add(36'hA2, 1, 0);
        exp_add(36'hB0, 1, 1);
        check_log("t3/t4");

        // 5: over-length transaction truncated at MAX_BEATS
        pulses = 0;
        for (int i = 0; i < 6; i++) drive(V, 36'(i), 1);
        drive(D, 36'h6, 1);
        idle(1);
        drive(V, 36'h10, 1);
        drive(D, 36'h11, 1);
        idle(4);
        exp_add(36'h0, 0, 0); exp_add(36'h1, 0, 0); exp_add(36'h2, 0, 0);
        exp_add(36'h3, 1, 1); exp_add(36'h10, 0, 0); exp_add(36'h11, 1, 0);
        check_log("t5");
        chk("t5 pulses", pulses, 1);
        chk("t5 drop_cnt", drop_cnt, 2);

        // 6: asynchronous reset mid-transaction
        out_ready = 1'b0;
        drive(V, 36'h20, 1);
        drive(V, 36'h21, 1);
        chk("t6 pre fifo_count", fifo_count, 2);
        chk("t6 pre busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("t6 rst out_valid", out_valid, 0);
        chk("t6 rst fifo_count", fifo_count, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst drop_cnt", drop_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        lw.delete(); ll.delete(); le.delete();
        in_hero = '0;
        @(posedge clk); #1;
        drive(D, 36'h30, 1);
        idle(3);
        exp_add(36'h30, 1, 0);
        check_log("t6");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
